if_id_fetch_buffer: RTL



---
 rtl/if_id_fetch_buffer.sv | 108 ++++++++++
 1 files changed

// File: rtl/if_id_fetch_buffer.sv
// IF/ID decoupling buffer: a circular queue of fetched instructions, presenting the
// oldest entry to decode and discarding everything on a pipeline flush.

package if_id_fetch_buffer_pkg;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        delayslot;
        logic        adel;
    } fetch_entry_t;
endpackage

module if_id_fetch_buffer
    import if_id_fetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [31:0]              in_pc,
    input  logic                     in_delayslot,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              instrD,
    output logic [31:0]              pcD,
    output logic                     delayslotD,
    output logic                     adelD,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t    mem [DEPTH];
    fetch_entry_t    head;
    fetch_entry_t    wr_entry;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count_q;
    logic [31:0]     last_pc;
    logic            push;
    logic            pop;
    logic            in_adel;

    // Handshake flags decode from registered occupancy only.
    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign push    = in_valid & in_ready & ~flush;
    assign pop     = out_valid & out_ready & ~flush;
    assign in_adel = (in_pc[1:0] != 2'b00);

    // Misaligned fetches store a nop so decode sees no spurious controls.
    always_comb begin
        wr_entry.instr     = in_adel ? 32'h0 : in_instr;
        wr_entry.pc        = in_pc;
        wr_entry.delayslot = in_delayslot;
        wr_entry.adel      = in_adel;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            last_pc <= RESET_PC;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PW'(1);
                last_pc <= mem[rd_ptr].pc;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Head view; pcD falls back to the last consumed PC while empty.
    always_comb begin
        head       = mem[rd_ptr];
        instrD     = out_valid ? head.instr : 32'h0;
        pcD        = out_valid ? head.pc : last_pc;
        delayslotD = out_valid & head.delayslot;
        adelD      = out_valid & head.adel;
    end

endmodule
